// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory arbiter.
//   state_e    - arbiter FSM states
//   client_e   - which client owns / last owned the controller
//   mc_req_t   - one controller request {wr, len, addr, value}
//   LEN_*      - controller length encoding (len[1:0] = size, len[2] = signed load)
//   SPACER_REQ - dummy read issued to break the controller's repeat shortcut
//   is_io()    - true for the IO window, which must never be buffered
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SPACER = 2'd1,
    ST_BUSY   = 2'd2
  } state_e;

  typedef enum logic {
    CLI_IF = 1'b0,
    CLI_LS = 1'b1
  } client_e;

  localparam logic [1:0] LEN_B = 2'b00;
  localparam logic [1:0] LEN_H = 2'b01;
  localparam logic [1:0] LEN_W = 2'b10;
  localparam int         LEN_SIGN_BIT = 2;
  localparam logic [2:0] LEN_SIGNED   = 3'b100;

  // Instruction fetch is always an unsigned word.
  localparam logic [2:0] LEN_FETCH = {1'b0, LEN_W};

  typedef struct packed {
    logic        wr;
    logic [2:0]  len;
    logic [31:0] addr;
    logic [31:0] value;
  } mc_req_t;

  localparam mc_req_t SPACER_REQ = '{wr: 1'b0, len: {1'b0, LEN_B}, addr: 32'h0, value: 32'h0};

  function automatic logic is_io(input logic [31:0] addr);
    return addr[17:16] == 2'b11;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: request/response bus between the arbiter and the
// byte-serial memory controller.
//   mc_waiting/mc_wr/mc_len/mc_addr/mc_value - request, held until mc_ready
//   mc_ready/mc_result                       - completion and read data
//   master: arbiter side, slave: controller side
interface mem_arbiter_if;
  logic        mc_waiting;
  logic        mc_wr;
  logic [2:0]  mc_len;
  logic [31:0] mc_addr;
  logic [31:0] mc_value;
  logic        mc_ready;
  logic [31:0] mc_result;

  modport master (
    output mc_waiting, mc_wr, mc_len, mc_addr, mc_value,
    input  mc_ready, mc_result
  );

  modport slave (
    input  mc_waiting, mc_wr, mc_len, mc_addr, mc_value,
    output mc_ready, mc_result
  );
endinterface

// File: rtl/mem_arb_read_buf.sv
// mem_arb_read_buf: one-entry read buffer {len, addr, data} in front of the
// memory controller. Only built when MEM_ARB_READ_BUF_EN is defined.
//   lookup_*  - request being granted this cycle; hit/hit_data answer it
//   fill*     - completed controller transaction (write invalidates,
//               non-IO read refills)
`ifdef MEM_ARB_READ_BUF_EN
module mem_arb_read_buf
  import mem_arb_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic        lookup_wr,
  input  logic [2:0]  lookup_len,
  input  logic [31:0] lookup_addr,
  output logic        hit,
  output logic [31:0] hit_data,
  input  logic        fill,
  input  logic        fill_wr,
  input  logic [2:0]  fill_len,
  input  logic [31:0] fill_addr,
  input  logic [31:0] fill_data
);

  logic        vld_q;
  logic [2:0]  len_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;

  assign hit = vld_q && !lookup_wr && !is_io(lookup_addr) &&
               (lookup_len == len_q) && (lookup_addr == addr_q);
  assign hit_data = data_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vld_q  <= 1'b0;
      len_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else if (rdy_in && fill) begin
      // Any write may alias the buffered word, so drop it outright.
      if (fill_wr) begin
        vld_q <= 1'b0;
      end else if (!is_io(fill_addr)) begin
        vld_q  <= 1'b1;
        len_q  <= fill_len;
        addr_q <= fill_addr;
        data_q <= fill_data;
      end
    end
  end

endmodule
`endif

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants IF fetches and LS loads/stores one at a time onto the
// byte-serial memory controller and returns results with a done pulse.
//   clk_in, rst_n_in (async, active low), rdy_in (global pause)
//   RoB_clear              - flush: abandon the current request, no done
//   if_req/if_addr         - word fetch;  if_done/if_data completion
//   ls_req/ls_wr/ls_len/ls_addr/ls_value - load/store; ls_done/ls_data
//   mc (master modport)    - controller request/response bus
// A request identical to the controller's last completed one is preceded by
// a zero spacer read, otherwise the controller would answer it instantly
// with the previous (possibly stale) result.
// Optional: MEM_ARB_READ_BUF_EN adds a one-entry read buffer.
module mem_arbiter (
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic          rdy_in,
  input  logic          RoB_clear,
  input  logic          if_req,
  input  logic [31:0]   if_addr,
  output logic          if_done,
  output logic [31:0]   if_data,
  input  logic          ls_req,
  input  logic          ls_wr,
  input  logic [2:0]    ls_len,
  input  logic [31:0]   ls_addr,
  input  logic [31:0]   ls_value,
  output logic          ls_done,
  output logic [31:0]   ls_data,
  mem_arbiter_if.master mc
);
  import mem_arb_pkg::*;

  state_e  state_q, state_d;
  client_e last_q, gnt_q, pick;
  mc_req_t req_q, prev_q, if_fields, ls_fields, new_req, mc_out;
  logic    prev_valid_q;
  logic    if_done_q, ls_done_q;
  logic [31:0] if_data_q, ls_data_q;
  logic    if_act, ls_act, grant, repeat_hit, buf_hit;
  logic    busy_done, spacer_done, waiting;

  // A client's request is ignored while its done pulse is out: it is still
  // high for that one cycle under the client handshake.
  assign if_act = if_req && !if_done_q;
  assign ls_act = ls_req && !ls_done_q;

  assign if_fields = '{wr: 1'b0, len: LEN_FETCH, addr: if_addr, value: 32'h0};
  assign ls_fields = '{wr: ls_wr, len: ls_len, addr: ls_addr, value: ls_value};

  // Tie goes to whoever did not get the last grant.
  assign pick    = (ls_act && (!if_act || last_q == CLI_IF)) ? CLI_LS : CLI_IF;
  assign new_req = (pick == CLI_LS) ? ls_fields : if_fields;

  assign grant       = (state_q == ST_IDLE) && (if_act || ls_act) && !RoB_clear;
  assign repeat_hit  = prev_valid_q && (new_req == prev_q);
  assign busy_done   = (state_q == ST_BUSY)   && mc.mc_ready && !RoB_clear;
  assign spacer_done = (state_q == ST_SPACER) && mc.mc_ready && !RoB_clear;

`ifdef MEM_ARB_READ_BUF_EN
  logic [31:0] buf_data;

  mem_arb_read_buf u_read_buf (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .rdy_in      (rdy_in),
    .lookup_wr   (new_req.wr),
    .lookup_len  (new_req.len),
    .lookup_addr (new_req.addr),
    .hit         (buf_hit),
    .hit_data    (buf_data),
    .fill        (busy_done),
    .fill_wr     (req_q.wr),
    .fill_len    (req_q.len),
    .fill_addr   (req_q.addr),
    .fill_data   (mc.mc_result)
  );
`else
  assign buf_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    waiting = 1'b0;
    mc_out  = '0;
    case (state_q)
      ST_IDLE: begin
        if (grant && !buf_hit) state_d = repeat_hit ? ST_SPACER : ST_BUSY;
      end
      ST_SPACER: begin
        waiting = 1'b1;
        mc_out  = SPACER_REQ;
        if (mc.mc_ready) state_d = ST_BUSY;
      end
      ST_BUSY: begin
        waiting = 1'b1;
        mc_out  = req_q;
        if (mc.mc_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (RoB_clear) state_d = ST_IDLE;
  end

  assign mc.mc_waiting = waiting;
  assign mc.mc_wr      = mc_out.wr;
  assign mc.mc_len     = mc_out.len;
  assign mc.mc_addr    = mc_out.addr;
  assign mc.mc_value   = mc_out.value;

  assign if_done = if_done_q;
  assign if_data = if_data_q;
  assign ls_done = ls_done_q;
  assign ls_data = ls_data_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= ST_IDLE;
      last_q       <= CLI_IF;
      gnt_q        <= CLI_IF;
      req_q        <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      if_done_q    <= 1'b0;
      ls_done_q    <= 1'b0;
      if_data_q    <= '0;
      ls_data_q    <= '0;
    end else if (rdy_in) begin
      state_q   <= state_d;
      if_done_q <= 1'b0;
      ls_done_q <= 1'b0;
      if (grant) begin
        last_q <= pick;
        gnt_q  <= pick;
        req_q  <= new_req;
      end
`ifdef MEM_ARB_READ_BUF_EN
      if (grant && buf_hit) begin
        if (pick == CLI_LS) begin
          ls_done_q <= 1'b1;
          ls_data_q <= buf_data;
        end else begin
          if_done_q <= 1'b1;
          if_data_q <= buf_data;
        end
      end
`endif
      // The controller latches the spacer too, so it becomes the new prev.
      if (spacer_done) begin
        prev_q       <= SPACER_REQ;
        prev_valid_q <= 1'b1;
      end
      if (busy_done) begin
        prev_q       <= req_q;
        prev_valid_q <= 1'b1;
        if (gnt_q == CLI_LS) begin
          ls_done_q <= 1'b1;
          ls_data_q <= req_q.wr ? 32'h0 : mc.mc_result;
        end else begin
          if_done_q <= 1'b1;
          if_data_q <= mc.mc_result;
        end
      end
      // Flush resets the controller's latched request as well.
      if (RoB_clear) prev_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        RoB_clear = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_done;
  logic [31:0] if_data;
  logic        ls_req = 1'b0;
  logic        ls_wr = 1'b0;
  logic [2:0]  ls_len = '0;
  logic [31:0] ls_addr = '0;
  logic [31:0] ls_value = '0;
  logic        ls_done;
  logic [31:0] ls_data;

  mem_arbiter_if mc();

  mem_arbiter dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .RoB_clear(RoB_clear),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_len(ls_len), .ls_addr(ls_addr),
    .ls_value(ls_value), .ls_done(ls_done), .ls_data(ls_data), .mc(mc)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- controller model ----------------
  function automatic int lat(input logic [2:0] len);
    case (len[1:0])
      LEN_B:   return 1;
      LEN_H:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a == 32'h1000) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  int cnt;
  int n_wr = 0;
  int n_sp = 0;
  assign mc.mc_ready  = mc.mc_waiting && (cnt == lat(mc.mc_len));
  assign mc.mc_result = mem_rd(mc.mc_addr);

  // Ready N cycles after a request appears (after waiting rises or after
  // the previous ready).
  always @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) cnt <= 0;
    else if (rdy_in) begin
      if (!mc.mc_waiting || mc.mc_ready) cnt <= 0;
      else cnt <= cnt + 1;
    end
  end

  always @(posedge clk_in) begin
    if (rst_n_in && rdy_in && mc.mc_ready) begin
      if (mc.mc_wr) n_wr <= n_wr + 1;
      else if (mc.mc_addr == 32'h0 && mc.mc_len == 3'b000) n_sp <= n_sp + 1;
    end
  end

  // ---------------- transaction-level arbiter model ----------------
  // t counts active (rdy_in high) cycles since reset. A grant at t=G finishes
  // with done at G + 2 + N (+2 if a spacer is needed).
  int      t, m_g, m_fin, d_t;
  logic    m_act, m_cli, m_sp, m_last, m_pv, d_cli;
  mc_req_t m_req, m_prev;
  logic [31:0] m_data, d_data;
  logic    b_v;
  logic [2:0]  b_len;
  logic [31:0] b_addr, b_data;

  always @(negedge clk_in) begin
    mc_req_t e_req, rq;
    logic e_wait, r_if, r_ls, w, hit;
    if (!rst_n_in) begin
      chk("rst_ctl", 32'({if_done, ls_done, mc.mc_waiting, mc.mc_wr, mc.mc_len}), 32'd0);
      chk("rst_bus", mc.mc_addr | mc.mc_value | if_data | ls_data, 32'd0);
      t = 0; m_act = 1'b0; m_last = 1'b0; m_pv = 1'b0; d_t = -1; d_cli = 1'b0;
      d_data = '0; b_v = 1'b0; m_g = 0; m_fin = 0; m_sp = 1'b0; m_cli = 1'b0;
      m_req = '0; m_prev = '0; m_data = '0; b_len = '0; b_addr = '0; b_data = '0;
    end else begin
      e_wait = m_act && (t > m_g);
      e_req = '0;
      if (e_wait) e_req = (m_sp && t <= m_g + 2) ? mc_req_t'('0) : m_req;
      chk("mc_waiting", 32'(mc.mc_waiting), 32'(e_wait));
      chk("mc_wr_len", 32'({mc.mc_wr, mc.mc_len}), 32'({e_req.wr, e_req.len}));
      chk("mc_addr", mc.mc_addr, e_req.addr);
      chk("mc_value", mc.mc_value, e_req.value);
      chk("if_done", 32'(if_done), 32'(d_t == t && !d_cli));
      chk("ls_done", 32'(ls_done), 32'(d_t == t && d_cli));
      if (d_t == t && !d_cli) chk("if_data", if_data, d_data);
      if (d_t == t && d_cli)  chk("ls_data", ls_data, d_data);
      if (rdy_in) begin
        if (RoB_clear) begin
          m_act = 1'b0;
          m_pv  = 1'b0;
        end else if (m_act) begin
          if (t == m_fin - 1) begin
            m_pv = 1'b1; m_prev = m_req;
            d_t = t + 1; d_cli = m_cli; d_data = m_data;
            if (m_req.wr) b_v = 1'b0;
            else if (!is_io(m_req.addr)) begin
              b_v = 1'b1; b_len = m_req.len; b_addr = m_req.addr; b_data = m_data;
            end
            m_act = 1'b0;
          end
        end else begin
          r_if = if_req && !(d_t == t && !d_cli);
          r_ls = ls_req && !(d_t == t && d_cli);
          if (r_if || r_ls) begin
            w = r_ls && (!r_if || !m_last);
            rq = w ? '{wr: ls_wr, len: ls_len, addr: ls_addr, value: ls_value}
                   : '{wr: 1'b0, len: 3'b010, addr: if_addr, value: 32'h0};
            m_last = w;
            hit = 1'b0;
`ifdef MEM_ARB_READ_BUF_EN
            hit = b_v && !rq.wr && !is_io(rq.addr) && rq.len == b_len && rq.addr == b_addr;
`endif
            if (hit) begin
              d_t = t + 1; d_cli = w; d_data = b_data;
            end else begin
              m_act = 1'b1; m_cli = w; m_g = t; m_req = rq;
              m_sp = m_pv && (rq == m_prev);
              m_fin = t + 2 + (m_sp ? 2 : 0) + lat(rq.len);
              m_data = rq.wr ? 32'h0 : mem_rd(rq.addr);
            end
          end
        end
        t++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic ls_start(input logic wr, input logic [2:0] len, input logic [31:0] a, input logic [31:0] v);
    ls_wr = wr; ls_len = len; ls_addr = a; ls_value = v; ls_req = 1'b1;
  endtask

  task automatic wait_done(input bit is_ls, output int d, output logic [31:0] data);
    bit seen;
    seen = 1'b0; d = -1; data = '0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk_in); #1;
      if (is_ls ? ls_done : if_done) begin
        seen = 1'b1; d = cyc; data = is_ls ? ls_data : if_data;
        break;
      end
    end
    chk(is_ls ? "ls_done_seen" : "if_done_seen", 32'(seen), 32'd1);
    @(posedge clk_in); #1;
    if (is_ls) ls_req = 1'b0; else if_req = 1'b0;
  endtask

  initial begin
    int g, di, dl, w0, s0;
    logic [31:0] xi, xl, x0;
    repeat (3) @(posedge clk_in);
    #1 rst_n_in = 1'b1;
    @(posedge clk_in); #1;

    // Lone word fetch: request at G, bus at G+1, done at G+6.
    if_addr = 32'h1000; if_req = 1'b1; g = cyc;
    @(posedge clk_in); #1;
    chk("fetch_g1_waiting", 32'(mc.mc_waiting), 32'd1);
    chk("fetch_g1_len", 32'(mc.mc_len), 32'b010);
    chk("fetch_g1_addr", mc.mc_addr, 32'h1000);
    wait_done(1'b0, di, xi);
    chk("fetch_latency", di - g, 32'd6);
    chk("fetch_data", xi, 32'hDEADBEEF);

    // Reset while the controller is busy.
    if_addr = 32'h2000; if_req = 1'b1;
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    chk("pre_rst_waiting", 32'(mc.mc_waiting), 32'd1);
    rst_n_in = 1'b0; if_req = 1'b0;
    #1;
    chk("rst_async_waiting", 32'(mc.mc_waiting), 32'd0);
    chk("rst_async_addr", mc.mc_addr, 32'd0);
    @(posedge clk_in); #1;
    rst_n_in = 1'b1;
    @(posedge clk_in); #1;

    // Tie right after reset: LS first (byte, done G+3), then IF (G+9).
    g = cyc;
    fork
      begin ls_start(1'b0, LEN_SIGNED, 32'h2000, 32'h0); wait_done(1'b1, dl, xl); end
      begin if_addr = 32'h1000; if_req = 1'b1; wait_done(1'b0, di, xi); end
    join
    chk("tie1_ls_lat", dl - g, 32'd3);
    chk("tie1_if_lat", di - g, 32'd9);
    chk("tie1_ls_data", xl, mem_rd(32'h2000));

    // Last grant was IF, so the next tie is LS again.
    g = cyc;
    fork
      begin ls_start(1'b0, LEN_SIGNED, 32'h2000, 32'h0); wait_done(1'b1, dl, xl); end
      begin if_addr = 32'h1000; if_req = 1'b1; wait_done(1'b0, di, xi); end
    join
    chk("tie2_ls_lat", dl - g, 32'd3);
    chk("tie2_if_lat", di - g, 32'd9);

    // After a lone LS grant, a tie goes to IF.
    ls_start(1'b0, LEN_SIGNED, 32'h2004, 32'h0);
    wait_done(1'b1, dl, xl);
    g = cyc;
    fork
      begin ls_start(1'b0, LEN_SIGNED, 32'h2000, 32'h0); wait_done(1'b1, dl, xl); end
      begin if_addr = 32'h1000; if_req = 1'b1; wait_done(1'b0, di, xi); end
    join
    chk("tie3_if_lat", di - g, 32'd6);
    chk("tie3_ls_lat", dl - g, 32'd9);

    // Identical IO writes: the second needs a spacer (+2 cycles).
    w0 = n_wr; s0 = n_sp;
    g = cyc;
    ls_start(1'b1, 3'b000, 32'h30000, 32'h41);
    wait_done(1'b1, dl, xl);
    chk("wr1_lat", dl - g, 32'd3);
    chk("wr1_data", xl, 32'd0);
    g = cyc;
    ls_start(1'b1, 3'b000, 32'h30000, 32'h41);
    wait_done(1'b1, dl, xl);
    chk("wr2_spacer_lat", dl - g, 32'd5);
    chk("wr_count", n_wr - w0, 32'd2);
    chk("spacer_count", n_sp - s0, 32'd1);

    // Pause for 3 cycles mid-fetch: done moves from G+6 to G+9.
    if_addr = 32'h1004; if_req = 1'b1; g = cyc;
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    rdy_in = 1'b0;
    repeat (3) begin @(posedge clk_in); #1; end
    rdy_in = 1'b1;
    wait_done(1'b0, di, xi);
    chk("pause_lat", di - g, 32'd9);
    chk("pause_data", xi, mem_rd(32'h1004));

    // Flush in the same cycle as mc_ready: no done, prev forgotten.
    ls_start(1'b0, 3'b010, 32'h3000, 32'h0);
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
        @(posedge clk_in); #1;
        if (mc.mc_ready) begin seen = 1'b1; break; end
      end
      chk("clr_ready_seen", 32'(seen), 32'd1);
    end
    RoB_clear = 1'b1;
    @(posedge clk_in); #1;
    RoB_clear = 1'b0; ls_req = 1'b0;
    repeat (3) begin
      chk("clr_no_done", 32'(ls_done), 32'd0);
      chk("clr_idle", 32'(mc.mc_waiting), 32'd0);
      @(posedge clk_in); #1;
    end
    g = cyc;
    ls_start(1'b0, 3'b010, 32'h3000, 32'h0);
    @(posedge clk_in); #1;
    chk("clr_no_spacer_addr", mc.mc_addr, 32'h3000);
    wait_done(1'b1, dl, xl);
    chk("clr_reissue_lat", dl - g, 32'd6);

    // Repeated read of 0x100: buffer hit (G+1) or spacer path (G+8).
    ls_start(1'b0, 3'b010, 32'h100, 32'h0);
    wait_done(1'b1, dl, x0);
    g = cyc;
    ls_start(1'b0, 3'b010, 32'h100, 32'h0);
    wait_done(1'b1, dl, xl);
`ifdef MEM_ARB_READ_BUF_EN
    chk("rep_read_lat", dl - g, 32'd1);
`else
    chk("rep_read_lat", dl - g, 32'd8);
`endif
    chk("rep_read_data", xl, x0);
    // A store invalidates the buffer; the read goes to the controller.
    ls_start(1'b1, 3'b010, 32'h100, 32'h55);
    wait_done(1'b1, dl, xl);
    g = cyc;
    ls_start(1'b0, 3'b010, 32'h100, 32'h0);
    wait_done(1'b1, dl, xl);
    chk("post_store_read_lat", dl - g, 32'd6);

    repeat (3) @(posedge clk_in);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
